// File: rtl/pam_4_slicer.sv
// PAM-4 slicer: registered 4-level decision against thresholds -T, 0, +T.
// T optionally tracks channel gain as the mean |sample| over a window of valid samples.
module pam_4_slicer #(
    parameter int SIGNAL_RESOLUTION = 8,
    parameter int SYMBOL_SEPARATION = 48,
    parameter int LOG2_WINDOW       = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [SIGNAL_RESOLUTION-1:0] signal_in,
    input  logic                         signal_in_valid,
    input  logic                         adapt_en,
    output logic [1:0]                   symbol_out,
    output logic                         symbol_out_valid,
    output logic [SIGNAL_RESOLUTION-1:0] threshold_out,
    output logic                         threshold_update
);
    // state | meaning
    // IDLE  | adapt_en=0: accumulator/counter held at 0, T frozen
    // ACCUM | adapt_en=1: summing |x| of valid samples, T rewritten each full window

    localparam int R  = SIGNAL_RESOLUTION;
    localparam int L  = LOG2_WINDOW;
    localparam int AW = R + L;
    localparam logic [L-1:0] CNT_LAST = {L{1'b1}};

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [R-1:0]  thr, thr_nxt;
    logic [AW-1:0] acc, acc_nxt;
    logic [L-1:0]  cnt, cnt_nxt;
    logic          upd_nxt;
    logic [1:0]    sym_nxt;

    logic signed [R+1:0] x_ext, t_pos, t_neg;
    logic [R-1:0]        mag;
    logic [AW-1:0]       sum;
    logic [R-1:0]        t_new;
    logic                take;

    // Two extra bits let +T reach 2^(R-1) and -T reach -2^(R-1) without wrapping.
    assign x_ext = {{2{signal_in[R-1]}}, signal_in};
    assign t_pos = signed'({2'b00, thr});
    assign t_neg = -t_pos;

    assign mag   = signal_in[R-1] ? (~signal_in + 1'b1) : signal_in;
    assign sum   = acc + AW'(mag);
    assign t_new = sum[AW-1:L];
    assign take  = adapt_en && signal_in_valid;

    always_comb begin
        sym_nxt = 2'b11;
        if (x_ext < t_neg)
            sym_nxt = 2'b00;
        else if (signal_in[R-1])
            sym_nxt = 2'b01;
        else if (x_ext < t_pos)
            sym_nxt = 2'b10;
    end

    always_comb begin
        state_nxt = adapt_en ? ACCUM : IDLE;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        thr_nxt   = thr;
        upd_nxt   = 1'b0;

        unique case (state)
            IDLE: begin
                acc_nxt = '0;
                cnt_nxt = '0;
            end
            ACCUM: begin
                if (!adapt_en) begin
                    acc_nxt = '0;
                    cnt_nxt = '0;
                end
            end
        endcase

        // The edge that raises adapt_en already counts its sample.
        if (take) begin
            if (cnt == CNT_LAST) begin
                acc_nxt = '0;
                cnt_nxt = '0;
                upd_nxt = 1'b1;
                if (t_new != '0)
                    thr_nxt = t_new;
            end else begin
                acc_nxt = sum;
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state            <= IDLE;
            thr              <= R'(SYMBOL_SEPARATION);
            acc              <= '0;
            cnt              <= '0;
            symbol_out       <= 2'b00;
            symbol_out_valid <= 1'b0;
            threshold_update <= 1'b0;
        end else begin
            state            <= state_nxt;
            thr              <= thr_nxt;
            acc              <= acc_nxt;
            cnt              <= cnt_nxt;
            symbol_out_valid <= signal_in_valid;
            threshold_update <= upd_nxt;
            if (signal_in_valid)
                symbol_out <= sym_nxt;
        end
    end

    assign threshold_out = thr;

endmodule

// File: tb/tb_pam_4_slicer.sv
// Bench for pam_4_slicer: decision table, directed adaptation sequences and a
// randomized run, all checked against a queue-based mean-of-window model.
module tb_pam_4_slicer;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] signal_in = '0;
    logic       signal_in_valid = 1'b0;
    logic       adapt_en = 1'b0;
    logic [1:0] symbol_out;
    logic       symbol_out_valid;
    logic [7:0] threshold_out;
    logic       threshold_update;

    pam_4_slicer #(
        .SIGNAL_RESOLUTION(8),
        .SYMBOL_SEPARATION(48),
        .LOG2_WINDOW(4)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .signal_in(signal_in),
        .signal_in_valid(signal_in_valid),
        .adapt_en(adapt_en),
        .symbol_out(symbol_out),
        .symbol_out_valid(symbol_out_valid),
        .threshold_out(threshold_out),
        .threshold_update(threshold_update)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int n_upd  = 0;

    // reference model
    int m_t   = 48;
    int m_sym = 0;
    int m_vld = 0;
    int m_upd = 0;
    int win[$];

    typedef struct {
        int         x;
        logic [1:0] sym;
    } vec_t;
    vec_t vt[8];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int slice(input int x, input int t);
        if (x < -t) return 0;
        if (x < 0)  return 1;
        if (x < t)  return 2;
        return 3;
    endfunction

    task automatic model(input int x, input bit v, input bit a, input bit r);
        int s;
        if (!r) begin
            m_t = 48; m_sym = 0; m_vld = 0; m_upd = 0;
            win.delete();
            return;
        end
        m_vld = v;
        m_upd = 0;
        if (v) m_sym = slice(x, m_t);
        if (!a) begin
            win.delete();
        end else if (v) begin
            win.push_back(x < 0 ? -x : x);
            if (win.size() == 16) begin
                s = 0;
                foreach (win[i]) s += win[i];
                if (s / 16 != 0) m_t = s / 16;
                m_upd = 1;
                win.delete();
            end
        end
    endtask

    task automatic step(input int x, input bit v, input bit a, input bit r = 1'b1);
        @(negedge clk);
        rstn = r;
        signal_in = 8'(x);
        signal_in_valid = v;
        adapt_en = a;
        @(posedge clk);
        model(x, v, a, r);
        #1;
        check("symbol_out", int'(symbol_out), m_sym);
        check("symbol_out_valid", int'(symbol_out_valid), m_vld);
        check("threshold_out", int'(threshold_out), m_t);
        check("threshold_update", int'(threshold_update), m_upd);
        if (threshold_update) n_upd++;
    endtask

    task automatic window_alt(input int p, input int q);
        for (int i = 0; i < 16; i++) step((i % 2 == 0) ? p : q, 1'b1, 1'b1);
    endtask

    initial begin
        vt[0] = '{-72, 2'b00}; vt[1] = '{-24, 2'b01};
        vt[2] = '{24, 2'b10};  vt[3] = '{72, 2'b11};
        vt[4] = '{-48, 2'b01}; vt[5] = '{48, 2'b11};
        vt[6] = '{0, 2'b10};   vt[7] = '{-1, 2'b01};

        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0);
        check("reset_sym", int'(symbol_out), 0);
        check("reset_valid", int'(symbol_out_valid), 0);
        check("reset_thr", int'(threshold_out), 48);
        check("reset_upd", int'(threshold_update), 0);

        foreach (vt[i]) begin
            step(vt[i].x, 1'b1, 1'b0);
            check("table_sym", int'(symbol_out), int'(vt[i].sym));
            check("table_valid", int'(symbol_out_valid), 1);
        end
        step(0, 0, 0);
        check("table_valid_drop", int'(symbol_out_valid), 0);
        check("table_sym_hold", int'(symbol_out), 1);

        n_upd = 0;
        window_alt(72, -24);
        check("nominal_pulse", int'(threshold_update), 1);
        check("nominal_thr", int'(threshold_out), 48);
        step(0, 0, 1);
        check("nominal_pulse_count", n_upd, 1);

        n_upd = 0;
        window_alt(36, -12);
        check("half_pulse", int'(threshold_update), 1);
        check("half_thr", int'(threshold_out), 24);
        step(30, 1, 0);  check("half_30", int'(symbol_out), 3);
        step(20, 1, 0);  check("half_20", int'(symbol_out), 2);
        step(-30, 1, 0); check("half_m30", int'(symbol_out), 0);

        for (int i = 0; i < 16; i++) step(-128, 1, 1);
        check("neg128_thr", int'(threshold_out), 128);
        check("neg128_pulse", int'(threshold_update), 1);
        n_upd = 0;
        for (int i = 0; i < 16; i++) step(0, 1, 1);
        check("zero_pulse", int'(threshold_update), 1);
        check("zero_thr_hold", int'(threshold_out), 128);

        step(0, 0, 0);
        n_upd = 0;
        for (int i = 0; i < 10; i++) step(100, 1, 1);
        step(100, 1, 0);
        window_alt(36, -12);
        check("interrupt_count", n_upd, 1);
        check("interrupt_thr", int'(threshold_out), 24);

        n_upd = 0;
        for (int i = 0; i < 16; i++) begin
            step(60, 1, 1);
            if (i % 3 == 0) step(120, 0, 1);
        end
        check("gap_count", n_upd, 1);
        check("gap_thr", int'(threshold_out), 60);

        for (int i = 0; i < 5; i++) step(100, 1, 1);
        step(100, 1, 1, 0);
        check("rst_mid_thr", int'(threshold_out), 48);
        n_upd = 0;
        for (int i = 0; i < 15; i++) step((i % 2 == 0) ? 36 : -12, 1, 1);
        check("rst_clean_no_early", n_upd, 0);
        step(-12, 1, 1);
        check("rst_clean_pulse", int'(threshold_update), 1);
        check("rst_clean_thr", int'(threshold_out), 24);

        begin
            bit a = 1'b1;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 19) == 0) a = ~a;
                step(int'($urandom_range(0, 255)) - 128,
                     $urandom_range(0, 3) != 0, a,
                     $urandom_range(0, 79) != 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
